wavelet_sample_streamer: RTL and testbench
==========================================

// Module: wavelet_sample_streamer
// PURPOSE
//  Transmit side of the wavelet_transform sample interface. Buffers host samples in a FIFO and drives
//  each one onto o_value with a paced o_data_clk strobe, the form the wavelet block's i_data_clk/i_value
//  inputs accept. Captures the block's multiplexed output (gated by its active flag) once per sample.
//  Sits in the user project area between the host/LA logic and the wavelet core.
// PARAMETERS
//  DEPTH          8  FIFO entries; power of 2, >= 2
//  HIGH_CYCLES    4  cycles o_data_clk is held high per sample, >= 1
//  LOW_CYCLES     4  cycles o_data_clk is held low after each high phase, >= 1
//  CAPTURE_DELAY  2  cycle index after HIGH entry at which the result is sampled; < HIGH_CYCLES+LOW_CYCLES
// PORTS
//  wb_clk_i        in   1            single clock for all logic
//  wb_rst_i        in   1            asynchronous, active-high reset
//  i_enable        in   1            allow new samples to start
//  i_sample        in   8            sample to enqueue
//  i_sample_valid  in   1            push request
//  o_sample_ready  out  1            FIFO can accept (count < DEPTH)
//  o_fifo_count    out  log2(DEPTH)+1  current FIFO occupancy
//  o_busy          out  1            state != IDLE
//  o_data_clk      out  1            sample strobe -> wavelet i_data_clk
//  o_value         out  8            sample value -> wavelet i_value
//  i_wavelet_out   in   8            wavelet o_multiplexed_wavelet_out
//  i_active        in   1            wavelet o_active
//  o_result        out  8            last captured wavelet output
//  o_result_valid  out  1            one-cycle pulse when o_result updates
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, FIFO emptied, state IDLE, o_sample_ready=1, timers cleared.
//  FIFO: push when i_sample_valid & o_sample_ready; ready ignores a same-cycle pop (full FIFO refuses push
//   even if popping). Pop only from non-empty FIFO; data pushed in cycle t is poppable at t+1 earliest.
//   Simultaneous push+pop leaves count unchanged. Pointers wrap modulo DEPTH; order strictly FIFO.
//  FSM (registered outputs):
//   IDLE : o_data_clk=0. If i_enable & count>0: pop head into o_value, -> SETUP.
//   SETUP: 1 cycle; o_value stable, o_data_clk=0 (setup time for the receiver). -> HIGH.
//   HIGH : o_data_clk=1 for exactly HIGH_CYCLES cycles. -> LOW.
//   LOW  : o_data_clk=0 for exactly LOW_CYCLES cycles. At last LOW cycle: if i_enable & count>0, pop
//          next head into o_value and -> SETUP; else -> IDLE.
//  Back-to-back sample period = 1+HIGH_CYCLES+LOW_CYCLES cycles. o_value changes only on a pop; holds
//   the last sample while IDLE.
//  Latency: push at t into empty FIFO, enable high -> pop at t+1, o_value valid t+2, o_data_clk rises t+3.
//  i_enable low mid-sample: current SETUP/HIGH/LOW sequence completes in full, then IDLE; FIFO contents kept.
//  Capture: phase counter 0 on first HIGH cycle; on counter==CAPTURE_DELAY, if i_active then o_result
//   <= i_wavelet_out and o_result_valid=1 next cycle for exactly one cycle; if i_active=0 no update, no pulse.
//   At most one capture per sample; i_wavelet_out/i_active are same-domain, sampled directly.
//  Widths: counters sized from parameters; no arithmetic on sample data (pass-through).
// TESTING
//  1 Reset mid-HIGH with 3 samples queued -> o_data_clk=0 immediately, o_fifo_count=0, o_busy=0, ready=1.
//  2 Push 0x5A, enable=1 -> o_value=0x5A one cycle before o_data_clk rises; high exactly 4, low 4, then busy=0.
//  3 Disable, push 0x00..0x08 -> ready drops at count=8, 0x08 dropped; enable -> 8 strobes, period 9, order kept.
//  4 i_active=1, i_wavelet_out=0xC3 -> o_result=0xC3, one valid pulse per sample; i_active=0 -> no pulse.
//  5 Drop i_enable during HIGH of sample 1 of 4 -> sample 1 completes, IDLE, count=3; re-enable resumes sample 2.
//  6 Push at the LOW-exit pop cycle with count=1 -> count stays 1, both samples emitted in push order.

Source files
------------

// File: rtl/wavelet_sample_streamer.sv
// Transmit side of the wavelet sample interface: FIFO-buffered host samples driven out with a
// paced o_data_clk strobe, plus one gated capture of the wavelet result per sample.
module wavelet_sample_streamer #(
  parameter int DEPTH         = 8,
  parameter int HIGH_CYCLES   = 4,
  parameter int LOW_CYCLES    = 4,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     i_enable,
  input  logic [7:0]               i_sample,
  input  logic                     i_sample_valid,
  output logic                     o_sample_ready,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_busy,
  output logic                     o_data_clk,
  output logic [7:0]               o_value,
  input  logic [7:0]               i_wavelet_out,
  input  logic                     i_active,
  output logic [7:0]               o_result,
  output logic                     o_result_valid
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PERIOD = HIGH_CYCLES + LOW_CYCLES;
  localparam int PW     = $clog2(PERIOD);

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0] LOW_LAST  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] CAP_PH    = PW'(CAPTURE_DELAY);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic          r_data_clk, r_result_valid;
  logic [7:0]    r_value, r_result;

  logic w_push, w_pop, w_capture;
  logic [7:0] w_head;

  // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
  assign o_sample_ready = (r_count < FULL);
  assign w_push         = i_sample_valid & o_sample_ready;
  assign w_pop          = i_enable & (r_count != '0) &
                          ((r_state == IDLE) || (r_state == LOW && r_phase == LOW_LAST));
  assign w_head         = r_mem[r_rd_ptr];
  assign w_capture      = (r_state == HIGH || r_state == LOW) && (r_phase == CAP_PH) && i_active;

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_sample;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // r_phase runs 0..PERIOD-1 across HIGH then LOW; it times both phases and the capture point.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state        <= IDLE;
      r_phase        <= '0;
      r_data_clk     <= 1'b0;
      r_value        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_capture) begin
        r_result       <= i_wavelet_out;
        r_result_valid <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_value <= w_head;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_state    <= HIGH;
          r_data_clk <= 1'b1;
          r_phase    <= '0;
        end
        HIGH: begin
          r_phase <= r_phase + 1'b1;
          if (r_phase == HIGH_LAST) begin
            r_state    <= LOW;
            r_data_clk <= 1'b0;
          end
        end
        LOW: begin
          if (r_phase == LOW_LAST) begin
            if (w_pop) begin
              r_value <= w_head;
              r_state <= SETUP;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_fifo_count   = r_count;
  assign o_busy         = (r_state != IDLE);
  assign o_data_clk     = r_data_clk;
  assign o_value        = r_value;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_wavelet_sample_streamer.sv
// Directed bench for wavelet_sample_streamer: a per-cycle vector table for one full sample,
// plus hand-written sequences for reset, FIFO fill, enable drop and push-during-pop.
module tb_wavelet_sample_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, vld = 1'b0, act = 1'b0;
  logic [7:0] smp = '0, wout = '0;
  logic       ready, busy, dclk, rv;
  logic [3:0] cnt;
  logic [7:0] value, result;

  wavelet_sample_streamer #(.DEPTH(8), .HIGH_CYCLES(4), .LOW_CYCLES(4), .CAPTURE_DELAY(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .i_enable(en), .i_sample(smp), .i_sample_valid(vld),
    .o_sample_ready(ready), .o_fifo_count(cnt), .o_busy(busy), .o_data_clk(dclk),
    .o_value(value), .i_wavelet_out(wout), .i_active(act), .o_result(result),
    .o_result_valid(rv));

  always #5 clk = ~clk;

  typedef struct {
    logic en, vld; logic [7:0] smp; logic act; logic [7:0] wout;
    logic x_dclk; logic [7:0] x_val; logic x_busy; logic [3:0] x_cnt; logic x_rv; logic [7:0] x_res;
  } vec_t;

  vec_t tbl[11];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, rv_cnt = 0, rv_dbl = 0;
  logic prev_dclk = 1'b0, prev_rv = 1'b0;
  logic [7:0] strobe_val[$];
  int strobe_cyc[$];

  task automatic chk(input string nm, input logic [31:0] actv, input logic [31:0] expv);
    n_cmp++;
    if (actv !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, actv, expv);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the edge, strobes and pulses logged here.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (dclk && !prev_dclk) begin
      strobe_val.push_back(value);
      strobe_cyc.push_back(cyc);
    end
    if (rv) rv_cnt++;
    if (rv && prev_rv) rv_dbl++;
    prev_dclk = dclk;
    prev_rv   = rv;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_dclk(input logic lvl, input int maxc, input string nm);
    int k = 0;
    while (dclk !== lvl && k < maxc) begin tick(); k++; end
    if (dclk !== lvl) chk(nm, 32'(dclk), 32'(lvl));
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < maxc) begin tick(); k++; end
    if (busy !== 1'b0) chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic push(input logic [7:0] d);
    vld = 1'b1; smp = d; tick(); vld = 1'b0;
  endtask

  initial begin
    // Sample 0x5A with the wavelet reporting 0xC3 active; rows are the state after each edge.
    tbl[0]  = '{1'b1,1'b1,8'h5A,1'b1,8'hC3, 1'b0,8'h00,1'b0,4'd1,1'b0,8'h00};
    tbl[1]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b0,8'h5A,1'b1,4'd0,1'b0,8'h00};
    tbl[2]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b1,8'h5A,1'b1,4'd0,1'b0,8'h00};
    tbl[3]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b1,8'h5A,1'b1,4'd0,1'b0,8'h00};
    tbl[4]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b1,8'h5A,1'b1,4'd0,1'b0,8'h00};
    tbl[5]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b1,8'h5A,1'b1,4'd0,1'b1,8'hC3};
    tbl[6]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b0,8'h5A,1'b1,4'd0,1'b0,8'hC3};
    tbl[7]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b0,8'h5A,1'b1,4'd0,1'b0,8'hC3};
    tbl[8]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b0,8'h5A,1'b1,4'd0,1'b0,8'hC3};
    tbl[9]  = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b0,8'h5A,1'b1,4'd0,1'b0,8'hC3};
    tbl[10] = '{1'b1,1'b0,8'h00,1'b1,8'hC3, 1'b0,8'h5A,1'b0,4'd0,1'b0,8'hC3};

    // Reset state
    #12;
    chk("reset_state", {8'd0, dclk, value, busy, cnt, rv, result, ready},
                       {8'd0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1});
    @(posedge clk); #1; rst = 1'b0;

    // Reset mid-HIGH with 3 samples still queued
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    en = 1'b1;
    wait_dclk(1'b1, 10, "t1_rise_timeout");
    chk("t1_count_before_reset", 32'(cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_reset", {dclk, cnt, busy, ready, value}, {1'b0, 4'd0, 1'b0, 1'b1, 8'h00});
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Table: one full sample with capture
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en; vld = tbl[i].vld; smp = tbl[i].smp; act = tbl[i].act; wout = tbl[i].wout;
      tick();
      chk($sformatf("vec%0d", i), {9'd0, dclk, value, busy, cnt, rv, result},
          {9'd0, tbl[i].x_dclk, tbl[i].x_val, tbl[i].x_busy, tbl[i].x_cnt, tbl[i].x_rv, tbl[i].x_res});
    end
    vld = 1'b0;

    // Capture: one pulse per sample when active, none when inactive
    en = 1'b0; act = 1'b1; wout = 8'hA5;
    push(8'h31); push(8'h32);
    rv_cnt = 0; rv_dbl = 0;
    en = 1'b1;
    ticks(24);
    chk("t4_pulses_active", 32'(rv_cnt), 32'd2);
    chk("t4_pulse_width", 32'(rv_dbl), 32'd0);
    chk("t4_result", 32'(result), 32'hA5);
    act = 1'b0; wout = 8'h3C;
    rv_cnt = 0;
    push(8'h33);
    ticks(14);
    chk("t4_pulses_inactive", 32'(rv_cnt), 32'd0);
    chk("t4_result_held", 32'(result), 32'hA5);

    // Fill FIFO while disabled, then stream it out
    en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vld = 1'b1; smp = 8'(i);
      tick();
      if (i == 7) chk("t3_ready_full", {31'd0, ready}, 32'd0);
    end
    vld = 1'b0;
    chk("t3_count_full", 32'(cnt), 32'd8);
    strobe_val.delete(); strobe_cyc.delete();
    en = 1'b1;
    ticks(82);
    chk("t3_strobe_count", 32'(strobe_val.size()), 32'd8);
    for (int i = 0; i < strobe_val.size() && i < 8; i++) begin
      chk($sformatf("t3_order%0d", i), 32'(strobe_val[i]), 32'(i));
      if (i > 0) chk($sformatf("t3_period%0d", i), 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd9);
    end
    chk("t3_drained", {27'd0, busy, cnt}, 32'd0);

    // Drop enable during HIGH of sample 1 of 4
    en = 1'b0;
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    strobe_val.delete(); strobe_cyc.delete();
    en = 1'b1;
    wait_dclk(1'b1, 10, "t5_rise_timeout");
    en = 1'b0;
    wait_idle(15, "t5_idle_timeout");
    chk("t5_count", 32'(cnt), 32'd3);
    chk("t5_value", 32'(value), 32'h21);
    chk("t5_strobes", 32'(strobe_val.size()), 32'd1);
    ticks(5);
    chk("t5_still_idle", {27'd0, busy, cnt}, 32'd3);
    strobe_val.delete(); strobe_cyc.delete();
    en = 1'b1;
    wait_dclk(1'b1, 10, "t5_resume_timeout");
    chk("t5_resume_value", 32'(value), 32'h22);
    wait_idle(40, "t5_drain_timeout");
    chk("t5_order", {8'd0, strobe_val.size() == 3 ? {strobe_val[0], strobe_val[1], strobe_val[2]} : 24'd0},
                    32'h00222324);
    chk("t5_drained", 32'(cnt), 32'd0);

    // Push in the same cycle as the LOW-exit pop
    en = 1'b0;
    push(8'h61); push(8'h62);
    strobe_val.delete(); strobe_cyc.delete();
    en = 1'b1;
    wait_dclk(1'b1, 10, "t6_rise_timeout");
    wait_dclk(1'b0, 10, "t6_fall_timeout");
    ticks(3);
    chk("t6_count_before", 32'(cnt), 32'd1);
    vld = 1'b1; smp = 8'h63;
    tick();
    vld = 1'b0;
    chk("t6_count_same", 32'(cnt), 32'd1);
    chk("t6_popped_value", 32'(value), 32'h62);
    wait_idle(30, "t6_drain_timeout");
    chk("t6_order", {8'd0, strobe_val.size() == 3 ? {strobe_val[0], strobe_val[1], strobe_val[2]} : 24'd0},
                    32'h00616263);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
